// File: rtl/control_unit.sv
// Instruction sequencer for the 16-bit base processor: fetches a 9-bit instruction
// from din and steps T0..T3 to drive bus-source selects and register load enables.
module control_unit #(
    parameter int DATA_W = 16,
    parameter int IR_W   = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [2:0]        rout,
    output logic              din_en,
    output logic              gout,
    output logic [7:0]        rin,
    output logic              ain,
    output logic              gin,
    output logic              addsub,
    output logic              irin,
    output logic              done,
    output logic              busy
);

    // state | meaning
    // T0    | idle / fetch: IR loads from din when run is high
    // T1    | mv, mvi, reserved complete; add/sub load A from rx
    // T2    | add/sub: ALU result of A +/- ry captured in G
    // T3    | add/sub: G written back to rx
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic [7:0] rx_onehot;

    assign op        = ir_q[8:6];
    assign rx        = ir_q[5:3];
    assign ry        = ir_q[2:0];
    assign rx_onehot = 8'(1) << rx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        rout    = 3'd0;
        din_en  = 1'b0;
        gout    = 1'b0;
        rin     = 8'd0;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = 1'b0;
        irin    = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;

        // Outputs are forced quiet while reset is held, even if run is already high.
        if (!reset) begin
            busy = (state_q != T0);
            case (state_q)
                T0: begin
                    if (run) begin
                        irin    = 1'b1;
                        ir_d    = din[IR_W-1:0];
                        state_d = T1;
                    end
                end
                T1: begin
                    if (op == OP_MV) begin
                        rout    = ry;
                        rin     = rx_onehot;
                        done    = 1'b1;
                        state_d = T0;
                    end else if (op == OP_MVI) begin
                        din_en  = 1'b1;
                        rin     = rx_onehot;
                        done    = 1'b1;
                        state_d = T0;
                    end else if (op[2] == 1'b0) begin
                        rout    = rx;
                        ain     = 1'b1;
                        state_d = T2;
                    end else begin
                        done    = 1'b1;
                        state_d = T0;
                    end
                end
                T2: begin
                    rout    = ry;
                    gin     = 1'b1;
                    addsub  = op[0];
                    state_d = T3;
                end
                T3: begin
                    gout    = 1'b1;
                    rin     = rx_onehot;
                    addsub  = op[0];
                    done    = 1'b1;
                    state_d = T0;
                end
                default: state_d = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle stimulus and expected output vectors
// are queued together, then replayed and compared on the falling edge.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [2:0]  rout;
    logic        din_en, gout, ain, gin, addsub, irin, done, busy;
    logic [7:0]  rin;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        run;
        logic [15:0] din;
    } stim_t;

    stim_t       stim_q[$];
    logic [18:0] exp_q[$];
    logic [18:0] obs;

    assign obs = {rout, din_en, gout, rin, ain, gin, addsub, irin, done, busy};

    always #5 clk = ~clk;

    control_unit #(.DATA_W(16), .IR_W(9)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .rout   (rout),
        .din_en (din_en),
        .gout   (gout),
        .rin    (rin),
        .ain    (ain),
        .gin    (gin),
        .addsub (addsub),
        .irin   (irin),
        .done   (done),
        .busy   (busy)
    );

    function automatic logic [18:0] ev(input logic [2:0] r, input logic de, input logic g,
                                       input logic [7:0] ri, input logic a, input logic gi,
                                       input logic as, input logic ir, input logic d,
                                       input logic b);
        return {r, de, g, ri, a, gi, as, ir, d, b};
    endfunction

    localparam logic [18:0] IDLE  = 19'd0;
    localparam logic [18:0] FETCH = 19'b000_0_0_00000000_0_0_0_1_0_0;

    task automatic push(input logic r, input logic [15:0] d, input logic [18:0] e);
        stim_t s;
        s.run = r;
        s.din = d;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Each scenario task replays the queues starting at posedge+1.
    task automatic test_reset;
        reset = 1'b1;
        run   = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== IDLE) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want %h", obs, IDLE);
        end
        run = 1'b1;
        din = 16'o105;
        #1;
        n_cmp++;
        if (obs !== IDLE) begin
            n_bad++;
            $display("FAIL reset_run_masked: got %h want %h", obs, IDLE);
        end
        run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_mvi_mv;
        logic [18:0] e;
        stim_t s;
        push(1'b1, 16'o105,  FETCH);
        push(1'b0, 16'h0005, ev(3'd0, 1, 0, 8'h01, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'h0000, IDLE);
        push(1'b1, 16'o010,  FETCH);
        push(1'b0, 16'h0000, ev(3'd0, 0, 0, 8'h02, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'h0000, IDLE);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mvi_mv cyc%0d: got %h want %h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_add;
        logic [18:0] e;
        stim_t s;
        push(1'b1, 16'o201, FETCH);
        push(1'b0, 16'o000, ev(3'd0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
        push(1'b0, 16'o000, ev(3'd1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1));
        push(1'b0, 16'o000, ev(3'd0, 0, 1, 8'h01, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'o000, IDLE);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL add cyc%0d: got %h want %h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // run held high: sub, reserved, then mv fetched with no dead cycle between them.
    task automatic test_back_to_back;
        logic [18:0] e;
        stim_t s;
        push(1'b1, 16'o312, FETCH);
        push(1'b1, 16'o105, ev(3'd1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
        push(1'b1, 16'o105, ev(3'd2, 0, 0, 8'h00, 0, 1, 1, 0, 0, 1));
        push(1'b1, 16'o105, ev(3'd0, 0, 1, 8'h02, 0, 0, 1, 0, 1, 1));
        push(1'b1, 16'o777, FETCH);
        push(1'b1, 16'o105, ev(3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1));
        push(1'b1, 16'o027, FETCH);
        push(1'b0, 16'o105, ev(3'd7, 0, 0, 8'h04, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'o000, IDLE);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reserved;
        logic [18:0] e;
        stim_t s;
        push(1'b1, 16'o777, FETCH);
        push(1'b0, 16'o000, ev(3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1));
        push(1'b1, 16'o633, FETCH);
        push(1'b0, 16'o000, ev(3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'o000, IDLE);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reserved cyc%0d: got %h want %h", i, obs, e);
            end
            n_cmp++;
            if (!$onehot0(rin) || (din_en && gout)) begin
                n_bad++;
                $display("FAIL reserved_excl cyc%0d: rin %h din_en %b gout %b", i, rin, din_en, gout);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid;
        logic [18:0] e;
        stim_t s;
        push(1'b1, 16'o201, FETCH);
        push(1'b0, 16'o000, ev(3'd0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
        push(1'b0, 16'o000, ev(3'd1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 1));
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_mid_pre cyc%0d: got %h want %h", i, obs, e);
            end
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h want %h", obs, IDLE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_hold: got %h want %h", obs, IDLE);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_t0: got %h want %h", obs, IDLE);
        end
        push(1'b1, 16'o010, FETCH);
        push(1'b0, 16'o000, ev(3'd0, 0, 0, 8'h02, 0, 0, 0, 0, 1, 1));
        push(1'b0, 16'o000, IDLE);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            run = s.run;
            din = s.din;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_mid_refetch cyc%0d: got %h want %h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_mvi_mv();
        test_add();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
